// File: rtl/motor_drive_ctrl.sv
// Multi-channel H-bridge motor controller: shared PWM counter and ramp prescaler,
// per-channel ramped duty, dead-time on reversal, filtered overcurrent trip with lockout.
module motor_drive_ctrl #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned PW       = 8,
    parameter int unsigned RAMP_DIV = 256,
    parameter int unsigned DEAD     = 64,
    parameter int unsigned OC_FILT  = 16,
    parameter int unsigned OC_COOL  = 1000000,
    parameter int unsigned OC_MAX   = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NCH*PW-1:0] duty_cmd,
    input  logic [NCH-1:0]    dir_cmd,
    input  logic              stop,
    input  logic [NCH-1:0]    oc,
    input  logic              fault_clr,
    output logic [NCH-1:0]    en,
    output logic [2*NCH-1:0]  in,
    output logic [NCH-1:0]    fault,
    output logic [NCH-1:0]    lock,
    output logic [NCH-1:0]    at_speed
);

    localparam int unsigned PRE_W  = $clog2(RAMP_DIV + 1);
    localparam int unsigned DEAD_W = $clog2(DEAD + 1);
    localparam int unsigned FILT_W = $clog2(OC_FILT + 1);
    localparam int unsigned COOL_W = $clog2(OC_COOL + 1);
    localparam int unsigned TRIP_W = $clog2(OC_MAX + 1);
    localparam logic [PW-1:0] CNT_LAST = {{(PW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DEAD  = 3'd2,
        S_FAULT = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    logic [PW-1:0]    cnt;
    logic [PRE_W-1:0] presc;
    logic             ramp_tick;

    assign ramp_tick = (presc == PRE_W'(RAMP_DIV - 1));

    // Shared PWM counter (0..2^PW-2) and ramp prescaler
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt   <= '0;
            presc <= '0;
        end else begin
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + PW'(1);
            presc <= ramp_tick ? '0 : presc + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t            state, state_nxt;
        logic [PW-1:0]     cmd;
        logic [PW-1:0]     duty_act, duty_act_nxt, duty_tgt;
        logic              dir_q, dir_q_nxt;
        logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
        logic [COOL_W-1:0] cool_cnt, cool_cnt_nxt;
        logic [TRIP_W-1:0] trips, trips_nxt;
        logic [FILT_W-1:0] filt;
        logic [1:0]        oc_sync;
        logic              trip;
        logic              en_q, en_nxt;
        logic [1:0]        in_q, in_nxt;
        logic              fault_q, fault_nxt;
        logic              lock_q, lock_nxt;
        logic              at_speed_q, at_speed_nxt;

        assign cmd  = duty_cmd[i*PW +: PW];
        assign trip = (filt == FILT_W'(OC_FILT));

        // Overcurrent synchroniser and saturating consecutive-sample filter
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                oc_sync <= '0;
                filt    <= '0;
            end else begin
                oc_sync <= {oc_sync[0], oc[i]};
                if (!oc_sync[1]) begin
                    filt <= '0;
                end else if (!trip) begin
                    filt <= filt + FILT_W'(1);
                end
            end
        end

        always_comb begin
            state_nxt    = state;
            duty_act_nxt = duty_act;
            dir_q_nxt    = dir_q;
            dead_cnt_nxt = '0;
            cool_cnt_nxt = '0;
            trips_nxt    = trips;
            duty_tgt     = '0;

            unique case (state)
                S_IDLE: begin
                    duty_act_nxt = '0;
                    if ((cmd != '0) && !stop) begin
                        state_nxt = S_RUN;
                        dir_q_nxt = dir_cmd[i];
                    end
                end
                S_RUN: begin
                    duty_tgt = (stop || (dir_cmd[i] != dir_q)) ? '0 : cmd;
                    if ((duty_act == '0) && (duty_tgt == '0)) begin
                        state_nxt = (stop || (cmd == '0)) ? S_IDLE : S_DEAD;
                    end else if (ramp_tick) begin
                        if (duty_act < duty_tgt) begin
                            duty_act_nxt = duty_act + PW'(1);
                        end else if (duty_act > duty_tgt) begin
                            duty_act_nxt = duty_act - PW'(1);
                        end
                    end
                end
                S_DEAD: begin
                    duty_act_nxt = '0;
                    dead_cnt_nxt = dead_cnt + DEAD_W'(1);
                    if (dead_cnt == DEAD_W'(DEAD - 1)) begin
                        dead_cnt_nxt = '0;
                        state_nxt    = S_RUN;
                        dir_q_nxt    = dir_cmd[i];
                    end
                end
                S_FAULT: begin
                    duty_act_nxt = '0;
                    cool_cnt_nxt = cool_cnt + COOL_W'(1);
                    if (cool_cnt == COOL_W'(OC_COOL - 1)) begin
                        cool_cnt_nxt = '0;
                        state_nxt    = (trips >= TRIP_W'(OC_MAX)) ? S_LOCK : S_IDLE;
                    end
                end
                S_LOCK: begin
                    duty_act_nxt = '0;
                    if (fault_clr) begin
                        state_nxt = S_IDLE;
                        trips_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = S_IDLE;
                    duty_act_nxt = '0;
                end
            endcase

            // A filtered trip overrides every other transition
            if (trip && ((state == S_IDLE) || (state == S_RUN) || (state == S_DEAD))) begin
                state_nxt    = S_FAULT;
                duty_act_nxt = '0;
                dir_q_nxt    = dir_q;
                dead_cnt_nxt = '0;
                cool_cnt_nxt = '0;
                if (trips != TRIP_W'(OC_MAX)) begin
                    trips_nxt = trips + TRIP_W'(1);
                end
            end

            at_speed_nxt = (state_nxt == S_RUN) && (duty_act_nxt == cmd) && (cmd != '0);
            if (at_speed_nxt) begin
                trips_nxt = '0;
            end

            en_nxt    = (state_nxt == S_RUN) && (cnt < duty_act);
            in_nxt    = (state_nxt == S_RUN) ? (dir_q_nxt ? 2'b10 : 2'b01) : 2'b00;
            fault_nxt = (state_nxt == S_FAULT) || (state_nxt == S_LOCK);
            lock_nxt  = (state_nxt == S_LOCK);
        end

        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                state      <= S_IDLE;
                duty_act   <= '0;
                dir_q      <= 1'b0;
                dead_cnt   <= '0;
                cool_cnt   <= '0;
                trips      <= '0;
                en_q       <= 1'b0;
                in_q       <= 2'b00;
                fault_q    <= 1'b0;
                lock_q     <= 1'b0;
                at_speed_q <= 1'b0;
            end else begin
                state      <= state_nxt;
                duty_act   <= duty_act_nxt;
                dir_q      <= dir_q_nxt;
                dead_cnt   <= dead_cnt_nxt;
                cool_cnt   <= cool_cnt_nxt;
                trips      <= trips_nxt;
                en_q       <= en_nxt;
                in_q       <= in_nxt;
                fault_q    <= fault_nxt;
                lock_q     <= lock_nxt;
                at_speed_q <= at_speed_nxt;
            end
        end

        assign en[i]         = en_q;
        assign in[2*i +: 2]  = in_q;
        assign fault[i]      = fault_q;
        assign lock[i]       = lock_q;
        assign at_speed[i]   = at_speed_q;
    end

endmodule
